// File: rtl/rtype_wb_checker.sv
// Scoreboard for a random RV32I R-type stream: predicts each result at issue, queues {rd, result}
// in order and compares the queue head against the core's register writeback port.
module rtype_wb_checker #(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [31:0]      issue_instr,
    input  logic [31:0]      issue_rs1,
    input  logic [31:0]      issue_rs2,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             mismatch,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             overflow,
    output logic             unexpected,
    output logic             timeout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0]  TOUT_CNT  = TW'(TIMEOUT);
    localparam logic [6:0]     OP_RTYPE  = 7'b0110011;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic legal_op(input logic [6:0] f7, input logic [2:0] f3);
        return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    endfunction

    function automatic logic [31:0] alu(input logic alt, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, sa < sb};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_rtype, accept, push, illegal_hit, wb_act, pop, hit;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tcnt;
    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          unused_fields;

    assign opcode        = issue_instr[6:0];
    assign rd            = issue_instr[11:7];
    assign funct3        = issue_instr[14:12];
    assign funct7        = issue_instr[31:25];
    assign unused_fields = ^issue_instr[24:15];

    assign empty       = (count == '0);
    assign issue_ready = (count != FULL_CNT);
    assign is_rtype    = (opcode == OP_RTYPE);
    assign accept      = issue_valid && issue_ready;
    assign push        = accept && is_rtype && legal_op(funct7, funct3) && (rd != 5'd0);
    assign illegal_hit = accept && is_rtype && !legal_op(funct7, funct3);
    // Writes to x0 never reach the register file, so they are not writebacks at all.
    assign wb_act      = wb_valid && (wb_addr != 5'd0);
    assign pop         = wb_act && !empty;
    assign hit         = pop && (addr_mem[rd_ptr] == wb_addr) && (data_mem[rd_ptr] == wb_data);

    // Queue storage holds data only; validity is tracked by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= rd;
            data_mem[wr_ptr] <= alu(funct7[5], funct3, issue_rs1, issue_rs2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tcnt        <= '0;
            mismatch    <= 1'b0;
            match_cnt   <= '0;
            err_cnt     <= '0;
            illegal_cnt <= '0;
            overflow    <= 1'b0;
            unexpected  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            mismatch <= wb_act && !hit;
            if (hit)                 match_cnt   <= sat_inc(match_cnt);
            if (wb_act && !hit)      err_cnt     <= sat_inc(err_cnt);
            if (illegal_hit)         illegal_cnt <= sat_inc(illegal_cnt);
            if (issue_valid && !issue_ready) overflow   <= 1'b1;
            if (wb_act && empty)     unexpected  <= 1'b1;

            // Age of the head entry; holds at TIMEOUT once the flag has fired.
            if (pop || empty) begin
                tcnt <= '0;
            end else if (tcnt != TOUT_CNT) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == TOUT_CNT - 1'b1) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtype_wb_checker.sv
// Randomized and directed bench for rtype_wb_checker against a queue-based reference model.
module tb_rtype_wb_checker;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;
    localparam logic [6:0] OPR = 7'b0110011;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_instr, issue_rs1, issue_rs2;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             mismatch;
    logic [CNT_W-1:0] match_cnt, err_cnt, illegal_cnt;
    logic             overflow, unexpected, timeout, empty;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [4:0] rd; logic [31:0] res; } exp_t;
    exp_t q[$];
    int   m_match, m_err, m_ill, m_t;
    bit   m_mismatch, m_ovf, m_unexp, m_tout;

    rtype_wb_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .mismatch(mismatch), .match_cnt(match_cnt), .err_cnt(err_cnt), .illegal_cnt(illegal_cnt),
        .overflow(overflow), .unexpected(unexpected), .timeout(timeout), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, OPR};
    endfunction

    // Results from the ISA definitions, phrased independently of any shifter/comparator structure.
    function automatic logic [31:0] ref_result(input logic [6:0] f7, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] ones;
        sh = int'(b[4:0]);
        ones = 32'hFFFF_FFFF;
        case (f3)
            3'd0: return (f7 == 7'h20) ? a + (~b + 32'd1) : a + b;
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h20 && a[31]) ? ((a >> sh) | ~(ones >> sh)) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Drives one cycle of stimulus and advances the model to the state expected after the edge.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input bit wv, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int   pre;
        bit   popped;
        bit   legal;
        issue_valid = iv; issue_instr = ins; issue_rs1 = r1; issue_rs2 = r2;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        pre = q.size();
        popped = 0;
        m_mismatch = 0;
        if (iv && pre == DEPTH) m_ovf = 1;
        if (wv && wa != 5'd0) begin
            if (pre > 0) begin
                e = q.pop_front();
                popped = 1;
                if (e.rd == wa && e.res == wd) m_match++;
                else begin m_err++; m_mismatch = 1; end
            end else begin
                m_unexp = 1; m_err++; m_mismatch = 1;
            end
        end
        if (iv && pre < DEPTH && ins[6:0] == OPR) begin
            legal = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5));
            if (!legal) m_ill++;
            else if (ins[11:7] != 5'd0) q.push_back('{ins[11:7], ref_result(ins[31:25], ins[14:12], r1, r2)});
        end
        if (pre == 0 || popped) m_t = 0;
        else if (m_t < TIMEOUT) begin
            m_t++;
            if (m_t == TIMEOUT) m_tout = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        issue_valid = 0; wb_valid = 0; issue_instr = 0; issue_rs1 = 0; issue_rs2 = 0;
        wb_addr = 0; wb_data = 0;
        reset_n = 0;
        q.delete();
        m_match = 0; m_err = 0; m_ill = 0; m_t = 0;
        m_mismatch = 0; m_ovf = 0; m_unexp = 0; m_tout = 0;
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1 || issue_ready !== 1'b1) begin errors++;
            $display("FAIL reset_fifo: empty=%b ready=%b, need 1 1", empty, issue_ready); end
        checks++; if (match_cnt !== '0 || err_cnt !== '0 || illegal_cnt !== '0) begin errors++;
            $display("FAIL reset_cnt: %0d %0d %0d, need 0 0 0", match_cnt, err_cnt, illegal_cnt); end
        checks++; if ({mismatch, overflow, unexpected, timeout} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: %b, need 0000", {mismatch, overflow, unexpected, timeout}); end
        release_reset();
    endtask

    task automatic test_add_match();
        do_reset(); release_reset();
        cycle(1, rtype(7'h00, 3'd0, 5'd7), 32'd5, 32'd3, 0, 5'd0, 32'h0);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL add_queued: empty=%b, need 0", empty); end
        cycle(0, 32'h0, 32'h0, 32'h0, 1, 5'd7, 32'd8);
        checks++; if (match_cnt !== 16'd1 || mismatch !== 1'b0 || empty !== 1'b1) begin errors++;
            $display("FAIL add_match: match=%0d mm=%b empty=%b, need 1 0 1", match_cnt, mismatch, empty); end
    endtask

    task automatic test_sub_mismatch();
        do_reset(); release_reset();
        cycle(1, rtype(7'h20, 3'd0, 5'd9), 32'd0, 32'd1, 0, 5'd0, 32'h0);
        cycle(0, 32'h0, 32'h0, 32'h0, 1, 5'd9, 32'h0);
        checks++; if (mismatch !== 1'b1 || err_cnt !== 16'd1 || match_cnt !== 16'd0) begin errors++;
            $display("FAIL sub_mismatch: mm=%b err=%0d match=%0d, need 1 1 0", mismatch, err_cnt, match_cnt); end
        idle(1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mismatch_pulse: mm=%b, need 0", mismatch); end
    endtask

    task automatic test_shift_compare();
        do_reset(); release_reset();
        cycle(1, rtype(7'h20, 3'd5, 5'd5), 32'h8000_0000, 32'h21, 0, 5'd0, 32'h0);
        cycle(1, rtype(7'h00, 3'd3, 5'd6), 32'hFFFF_FFFF, 32'd1, 1, 5'd5, 32'hC000_0000);
        cycle(1, rtype(7'h00, 3'd2, 5'd7), 32'hFFFF_FFFF, 32'd1, 1, 5'd6, 32'd0);
        cycle(0, 32'h0, 32'h0, 32'h0, 1, 5'd7, 32'd1);
        checks++; if (match_cnt !== 16'd3 || err_cnt !== 16'd0) begin errors++;
            $display("FAIL sra_sltu_slt: match=%0d err=%0d, need 3 0", match_cnt, err_cnt); end
    endtask

    task automatic test_unexpected_ignored();
        do_reset(); release_reset();
        cycle(0, 32'h0, 32'h0, 32'h0, 1, 5'd3, 32'h1234);
        checks++; if (unexpected !== 1'b1 || err_cnt !== 16'd1 || mismatch !== 1'b1) begin errors++;
            $display("FAIL unexpected_wb: unexp=%b err=%0d mm=%b, need 1 1 1", unexpected, err_cnt, mismatch); end
        cycle(1, 32'h0000_0013, 32'd4, 32'd4, 1, 5'd0, 32'h55);
        cycle(1, rtype(7'h00, 3'd0, 5'd0), 32'd4, 32'd4, 0, 5'd0, 32'h0);
        checks++; if (err_cnt !== 16'd1 || match_cnt !== 16'd0 || illegal_cnt !== 16'd0 || empty !== 1'b1 || mismatch !== 1'b0) begin
            errors++; $display("FAIL ignored_ops: err=%0d match=%0d ill=%0d empty=%b mm=%b, need 1 0 0 1 0",
                                err_cnt, match_cnt, illegal_cnt, empty, mismatch); end
        cycle(1, rtype(7'h20, 3'd1, 5'd4), 32'd4, 32'd4, 0, 5'd0, 32'h0);
        checks++; if (illegal_cnt !== 16'd1 || empty !== 1'b1) begin errors++;
            $display("FAIL illegal: ill=%0d empty=%b, need 1 1", illegal_cnt, empty); end
    endtask

    task automatic test_overflow_timeout();
        do_reset(); release_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, rtype(7'h00, 3'd0, 5'd1), i, 32'd1, 0, 5'd0, 32'h0);
        checks++; if (issue_ready !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL full: ready=%b ovf=%b, need 0 0", issue_ready, overflow); end
        cycle(1, rtype(7'h00, 3'd0, 5'd1), 32'd9, 32'd1, 0, 5'd0, 32'h0);
        checks++; if (overflow !== 1'b1 || timeout !== 1'b0) begin errors++;
            $display("FAIL overflow: ovf=%b tout=%b, need 1 0", overflow, timeout); end
        idle(TIMEOUT);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout: tout=%b, need 1", timeout); end
    endtask

    task automatic test_full_same_cycle();
        do_reset(); release_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, rtype(7'h00, 3'd4, 5'(i + 1)), 32'hA5, i, 0, 5'd0, 32'h0);
        cycle(1, rtype(7'h00, 3'd0, 5'd20), 32'd1, 32'd1, 1, 5'd1, 32'hA5);
        checks++; if (overflow !== 1'b1 || match_cnt !== 16'd1 || issue_ready !== 1'b1) begin errors++;
            $display("FAIL full_push_pop: ovf=%b match=%0d ready=%b, need 1 1 1", overflow, match_cnt, issue_ready); end
        cycle(0, 32'h0, 32'h0, 32'h0, 1, 5'd2, 32'hA4);
        do_reset();
        checks++; if (empty !== 1'b1 || issue_ready !== 1'b1 || match_cnt !== '0 || err_cnt !== '0 ||
                      {mismatch, overflow, unexpected, timeout} !== 4'b0) begin errors++;
            $display("FAIL mid_reset: empty=%b ready=%b match=%0d err=%0d flags=%b, need 1 1 0 0 0000",
                     empty, issue_ready, match_cnt, err_cnt, {mismatch, overflow, unexpected, timeout}); end
        release_reset();
    endtask

    task automatic test_random();
        logic [31:0] ins, wd;
        logic [4:0]  wa;
        bit          iv, wv;
        int          sel;
        logic [2:0]  f3;
        do_reset(); release_reset();
        for (int n = 0; n < 400; n++) begin
            iv = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            if (sel < 5)       ins = rtype(7'h00, f3, 5'($urandom_range(0, 31)));
            else if (sel < 7)  ins = rtype(7'h20, ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd0, 5'($urandom_range(0, 31)));
            else if (sel == 7) ins = rtype(7'h01, f3, 5'($urandom_range(1, 31)));
            else if (sel == 8) ins = 32'h0000_0013;
            else               ins = $urandom;
            wv = 0; wa = 5'd0; wd = 32'h0;
            if (q.size() > 0 && $urandom_range(0, 9) < 5) begin
                wv = 1; wa = q[0].rd; wd = q[0].res;
                if ($urandom_range(0, 9) == 0) wd = wd ^ (32'd1 << $urandom_range(0, 31));
                else if ($urandom_range(0, 19) == 0) wa = 5'($urandom_range(0, 31));
            end else if ($urandom_range(0, 29) == 0) begin
                wv = 1; wa = 5'($urandom_range(0, 31)); wd = $urandom;
            end
            cycle(iv, ins, $urandom, (sel < 3) ? 32'($urandom_range(0, 40)) : $urandom, wv, wa, wd);
            checks++; if (match_cnt !== 16'(m_match) || err_cnt !== 16'(m_err) || illegal_cnt !== 16'(m_ill)) begin
                errors++; $display("FAIL rand_cnt[%0d]: %0d %0d %0d, need %0d %0d %0d",
                                    n, match_cnt, err_cnt, illegal_cnt, m_match, m_err, m_ill); end
            checks++; if ({mismatch, overflow, unexpected, timeout} !== {m_mismatch, m_ovf, m_unexp, m_tout} ||
                          empty !== (q.size() == 0) || issue_ready !== (q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_flags[%0d]: mm/ovf/unexp/tout=%b empty=%b ready=%b, need %b %b %b",
                                    n, {mismatch, overflow, unexpected, timeout}, empty, issue_ready,
                                    {m_mismatch, m_ovf, m_unexp, m_tout}, (q.size() == 0), (q.size() < DEPTH)); end
        end
    endtask

    initial begin
        test_reset();
        test_add_match();
        test_sub_mismatch();
        test_shift_compare();
        test_unexpected_ignored();
        test_overflow_timeout();
        test_full_same_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
